// File: rtl/vector_rr_packer.sv
// Round-robin arbiter over three nibble requesters, packing granted nibbles
// in grant order into a 3-slot word presented on a valid/ready interface.
module vector_rr_packer #(
  parameter int NIB_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_0,
  input  logic               req_1,
  input  logic               req_2,
  input  logic [NIB_W-1:0]   nib_0,
  input  logic [NIB_W-1:0]   nib_1,
  input  logic [NIB_W-1:0]   nib_2,
  output logic               gnt_0,
  output logic               gnt_1,
  output logic               gnt_2,
  input  logic               flush,
  output logic               word_valid,
  input  logic               word_ready,
  output logic [3*NIB_W-1:0] word_data,
  output logic [5:0]         word_src,
  output logic [1:0]         word_len
);
  typedef enum logic {FILL, FULL} state_t;

  state_t             r_state, w_state_n;
  logic [1:0]         r_cnt, w_cnt_n, r_ptr, w_ptr_n, r_len, w_len_n;
  logic [3*NIB_W-1:0] r_data, w_data_n;
  logic [5:0]         r_src, w_src_n;
  logic [2:0]         w_req, w_gnt;
  logic [1:0]         w_gid;
  logic [NIB_W-1:0]   w_nib;
  logic               w_gen, w_xfer;

  assign w_req = {req_2, req_1, req_0};
  // FULL with word_ready lets a nibble pass straight into slot 0 of the next word
  assign w_gen = !rst && (((r_state == FILL) && !flush) ||
                          ((r_state == FULL) && word_ready));

  always_comb begin : arb
    logic       found;
    logic [2:0] s;
    logic [1:0] idx;
    w_gnt = '0;
    w_gid = '0;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s   = {1'b0, r_ptr} + 3'(k);
      idx = (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
      if (w_gen && !found && w_req[idx]) begin
        found      = 1'b1;
        w_gnt[idx] = 1'b1;
        w_gid      = idx;
      end
    end
  end

  assign {gnt_2, gnt_1, gnt_0} = w_gnt;
  assign w_xfer = |w_gnt;
  assign w_nib  = (w_gid == 2'd2) ? nib_2 : (w_gid == 2'd1) ? nib_1 : nib_0;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_len_n   = r_len;
    w_data_n  = r_data;
    w_src_n   = r_src;
    w_ptr_n   = w_xfer ? ((w_gid == 2'd2) ? 2'd0 : w_gid + 2'd1) : r_ptr;
    case (r_state)
      FILL: begin
        if (flush) begin
          if (r_cnt != 2'd0) begin
            w_state_n = FULL;
            w_len_n   = r_cnt;
            w_cnt_n   = 2'd0;
          end
        end else if (w_xfer) begin
          w_data_n[r_cnt*NIB_W +: NIB_W] = w_nib;
          w_src_n[r_cnt*2 +: 2]          = w_gid;
          if (r_cnt == 2'd2) begin
            w_state_n = FULL;
            w_len_n   = 2'd3;
            w_cnt_n   = 2'd0;
          end else begin
            w_cnt_n = r_cnt + 2'd1;
          end
        end
      end
      FULL: begin
        if (word_ready) begin
          w_state_n = FILL;
          w_len_n   = 2'd0;
          w_data_n  = '0;
          w_src_n   = '0;
          w_cnt_n   = 2'd0;
          if (w_xfer) begin
            w_data_n[NIB_W-1:0] = w_nib;
            w_src_n[1:0]        = w_gid;
            w_cnt_n             = 2'd1;
          end
        end
      end
      default: w_state_n = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_len   <= '0;
      r_data  <= '0;
      r_src   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_ptr   <= w_ptr_n;
      r_len   <= w_len_n;
      r_data  <= w_data_n;
      r_src   <= w_src_n;
    end
  end

  // Slots hold partial data while filling; mask it until the word is offered
  assign word_valid = (r_state == FULL);
  assign word_data  = word_valid ? r_data : '0;
  assign word_src   = word_valid ? r_src  : '0;
  assign word_len   = word_valid ? r_len  : '0;
endmodule

// File: tb/tb_vector_rr_packer.sv
// Directed table-driven bench for vector_rr_packer, plus a hand-written
// asynchronous-reset sequence.
module tb_vector_rr_packer;
  logic        clk, rst;
  logic        req_0, req_1, req_2;
  logic [3:0]  nib_0, nib_1, nib_2;
  logic        gnt_0, gnt_1, gnt_2;
  logic        flush, word_valid, word_ready;
  logic [11:0] word_data;
  logic [5:0]  word_src;
  logic [1:0]  word_len;

  int checks = 0;
  int errors = 0;

  vector_rr_packer #(.NIB_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .req_1(req_1), .req_2(req_2),
    .nib_0(nib_0), .nib_1(nib_1), .nib_2(nib_2),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2),
    .flush(flush), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .word_src(word_src), .word_len(word_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [3:0]  n0, n1, n2;
    logic        flush, ready;
    logic [2:0]  gnt;
    logic        vld;
    logic [11:0] data;
    logic [5:0]  src;
    logic [1:0]  len;
  } vec_t;

  vec_t tv[$];

  function automatic void add(logic r, logic [2:0] rq, logic [3:0] a, logic [3:0] b,
                              logic [3:0] c, logic fl, logic rd, logic [2:0] g,
                              logic v, logic [11:0] d, logic [5:0] s, logic [1:0] l);
    vec_t e;
    e.rst = r; e.req = rq; e.n0 = a; e.n1 = b; e.n2 = c; e.flush = fl; e.ready = rd;
    e.gnt = g; e.vld = v; e.data = d; e.src = s; e.len = l;
    tv.push_back(e);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {11'd0, word_valid, word_data, word_src, word_len};
  endfunction

  initial begin
    rst = 1'b1; req_0 = 0; req_1 = 0; req_2 = 0;
    nib_0 = 0; nib_1 = 0; nib_2 = 0; flush = 0; word_ready = 0;

    // single requester 0: 1,2,3
    add(1, 3'b000, 0,0,0, 0,1, 3'b000, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b001, 1,0,0, 0,1, 3'b001, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b001, 2,0,0, 0,1, 3'b001, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b001, 3,0,0, 0,1, 3'b001, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b000, 0,0,0, 0,1, 3'b000, 1, 12'h321, 6'b000000, 3);
    add(0, 3'b000, 0,0,0, 0,1, 3'b000, 0, 12'h000, 6'b000000, 0);
    // contention, pass-through, then backpressure
    add(1, 3'b000, 0,0,0, 0,1, 3'b000, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b111, 5,6,7, 0,1, 3'b001, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b111, 5,6,7, 0,1, 3'b010, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b111, 5,6,7, 0,1, 3'b100, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b111, 5,6,7, 0,1, 3'b001, 1, 12'h765, 6'b100100, 3);
    add(0, 3'b111, 5,6,7, 0,1, 3'b010, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b111, 5,6,7, 0,1, 3'b100, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b111, 5,6,7, 0,1, 3'b001, 1, 12'h765, 6'b100100, 3);
    add(0, 3'b111, 5,6,7, 0,1, 3'b010, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b111, 5,6,7, 0,1, 3'b100, 0, 12'h000, 6'b000000, 0);
    for (int i = 0; i < 4; i++)
      add(0, 3'b111, 5,6,7, 0,0, 3'b000, 1, 12'h765, 6'b100100, 3);
    add(0, 3'b111, 5,6,7, 0,1, 3'b001, 1, 12'h765, 6'b100100, 3);
    add(0, 3'b000, 0,0,0, 1,1, 3'b000, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b000, 0,0,0, 0,1, 3'b000, 1, 12'h005, 6'b000000, 1);
    add(0, 3'b000, 0,0,0, 0,1, 3'b000, 0, 12'h000, 6'b000000, 0);
    // flush of a 2-slot partial word, then flush with nothing collected
    add(0, 3'b010, 0,4'hA,0, 0,1, 3'b010, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b100, 0,0,4'hB, 0,1, 3'b100, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b001, 0,0,0, 1,1, 3'b000, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b001, 0,0,0, 0,0, 3'b000, 1, 12'h0BA, 6'b001001, 2);
    add(0, 3'b000, 0,0,0, 0,1, 3'b000, 1, 12'h0BA, 6'b001001, 2);
    add(0, 3'b000, 0,0,0, 0,1, 3'b000, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b000, 0,0,0, 1,1, 3'b000, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b000, 0,0,0, 0,1, 3'b000, 0, 12'h000, 6'b000000, 0);
    // reset mid-word discards the partial word
    add(0, 3'b001, 1,0,0, 0,1, 3'b001, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b001, 2,0,0, 0,1, 3'b001, 0, 12'h000, 6'b000000, 0);
    add(1, 3'b001, 2,0,0, 0,1, 3'b000, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b100, 0,0,7, 0,1, 3'b100, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b100, 0,0,8, 0,1, 3'b100, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b100, 0,0,9, 0,1, 3'b100, 0, 12'h000, 6'b000000, 0);
    add(0, 3'b000, 0,0,0, 0,1, 3'b000, 1, 12'h987, 6'b101010, 3);
    add(0, 3'b000, 0,0,0, 0,1, 3'b000, 0, 12'h000, 6'b000000, 0);

    // hand sequence: asynchronous reset while a full word is held
    @(negedge clk);
    chk("reset_outs", outs(), 32'd0);
    chk("reset_gnt", {29'd0, gnt_2, gnt_1, gnt_0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_0 = 1'b1; nib_0 = 4'd1; word_ready = 1'b0;
    @(negedge clk);
    chk("first_gnt", {29'd0, gnt_2, gnt_1, gnt_0}, 32'd1);
    @(posedge clk); #1 nib_0 = 4'd2;
    @(posedge clk); #1 nib_0 = 4'd3;
    @(posedge clk); #1;
    @(negedge clk);
    chk("held_full", outs(), {11'd0, 1'b1, 12'h321, 6'b000000, 2'd3});
    chk("held_gnt", {29'd0, gnt_2, gnt_1, gnt_0}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outs", outs(), 32'd0);
    chk("async_rst_gnt", {29'd0, gnt_2, gnt_1, gnt_0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; word_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_outs", outs(), 32'd0);
    chk("post_rst_gnt", {29'd0, gnt_2, gnt_1, gnt_0}, 32'd1);

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      rst = tv[i].rst;
      {req_2, req_1, req_0} = tv[i].req;
      nib_0 = tv[i].n0; nib_1 = tv[i].n1; nib_2 = tv[i].n2;
      flush = tv[i].flush; word_ready = tv[i].ready;
      @(negedge clk);
      chk($sformatf("row%0d_gnt", i), {29'd0, gnt_2, gnt_1, gnt_0}, {29'd0, tv[i].gnt});
      chk($sformatf("row%0d_word", i), outs(),
          {11'd0, tv[i].vld, tv[i].data, tv[i].src, tv[i].len});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_rr_packer.md
# vector_rr_packer

Round-robin arbiter and packer that shares the nibble-concatenation datapath between three requesters. Each requester offers one NIB_W-bit nibble per handshake. Granted nibbles are packed, in grant order, into a 3-slot word, and that word is presented downstream on a valid/ready interface. The block sits in front of the vector concatenation logic and sequences its three nibble inputs from independent sources.

## Interface
Parameters:
- NIB_W, default 4, nibble width; output word width is 3*NIB_W.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_0, req_1, req_2  input  1 each  request. Must be held, with the nibble stable, until granted.
- nib_0, nib_1, nib_2  input  NIB_W each  nibble offered by each requester.
- gnt_0, gnt_1, gnt_2  output  1 each  combinational grant, at most one high. A nibble transfers on any cycle where req_i and gnt_i are both high.
- flush  input  1  single-cycle pulse. Emits the current partial word.
- word_valid  output  1  packed word available.
- word_ready  input  1  downstream accepts the word.
- word_data  output  3*NIB_W  packed word:
  - slot 0 (first grant) is in [NIB_W-1:0];
  - slot 1 is in [2*NIB_W-1:NIB_W];
  - slot 2 is in [3*NIB_W-1:2*NIB_W].
- word_src  output  6  2-bit requester ID per slot, with slot k in [2k+1:2k]; unused slots read 0.
- word_len  output  2  number of valid slots, 1 to 3.

## Operation
States:
- FILL: collecting nibbles. Slot counter cnt runs 0 to 2.
- FULL: word_valid=1 and holding.

Round-robin arbitration:
- Pointer ptr (0 to 2) names the highest-priority requester.
- Search order is ptr, ptr+1, ptr+2 (mod 3).
- After a grant to i, ptr becomes (i+1) mod 3. ptr does not change when no grant occurs.

Grant enable:
- Grants are enabled when state=FILL and flush=0.
- Grants are also enabled when state=FULL and word_ready=1 (pass-through). The accepted nibble becomes slot 0 of the next word.
- Otherwise all gnt are 0.

FILL transitions:
- On a transfer, the nibble is written to slot cnt, its ID to word_src slot cnt, and cnt increments.
- On the third transfer (cnt=2), go to FULL with word_len=3.
- flush=1 with cnt>0: go to FULL with word_len=cnt. Unfilled data and source slots are 0. No grant occurs that cycle.
- flush=1 with cnt=0: ignored.

FULL transitions:
- word_valid && word_ready: the word is consumed.
  - If a pass-through transfer occurred in the same cycle, go to FILL with cnt=1, slot 0 loaded, and other slots cleared.
  - Otherwise go to FILL with cnt=0 and all slots cleared.
- flush is ignored in FULL.

Output stability:
- word_data, word_src and word_len stay stable while word_valid=1 and word_ready=0.
- word_data, word_src and word_len read 0 whenever word_valid=0.

Reset:
- Asynchronous, effective immediately, including mid-word.
- State=FILL, cnt=0, ptr=0, and all slots cleared.
- Partial nibbles are discarded.

## Timing
- Reset values: word_valid=0, word_data=0, word_src=0, word_len=0. gnt_* are 0 while rst=1.
- gnt_* are combinational from req_*, ptr, state, cnt, flush and word_ready, with no added cycle.
- Transfer-to-output latency: word_valid rises on the clock edge that registers the third transfer, or the edge that samples flush.
- Sustained throughput: one nibble per cycle, so one full word per 3 cycles with word_ready=1 held high. There are no bubbles.
- Backpressure: while FULL and word_ready=0, all gnt are 0 and ptr holds.
- No requests: state, cnt and ptr hold indefinitely.

## Test plan
1. Reset:
   - Stimulus: assert rst asynchronously mid-cycle with req_0=1.
   - Response: word_valid, word_data, word_src, word_len and gnt_0 are 0 immediately. After release, the first grant goes to requester 0.
2. Single requester:
   - Stimulus: req_0 only, nib_0 = 1, 2, 3 on consecutive cycles, word_ready=1.
   - Response: gnt_0=1 on each of the 3 cycles. Next cycle: word_valid=1, word_data=12'h321, word_src=6'b000000, word_len=3.
3. Contention:
   - Stimulus: req_0, req_1, req_2 held high, nib_i = i+5, word_ready=1.
   - Response: grant order 0, 1, 2, 0, 1, 2. Each word is 12'h765 with word_src=6'b100100, and word_valid is high every third cycle.
4. Backpressure:
   - Stimulus: fill a word, then hold word_ready=0 for 4 cycles with requests pending.
   - Response: gnt_* are 0 and word_data is constant. On the cycle word_ready=1, the pending requester (ptr order) is granted and becomes slot 0 of the next word.
5. Flush:
   - Stimulus: grant nib_1=4'hA, then nib_2=4'hB, then pulse flush.
   - Response: word_data=12'h0BA, word_src=6'b001001, word_len=2, and no grant on the flush cycle.
   - Stimulus: flush with cnt=0.
   - Response: no word_valid.
6. Reset mid-word:
   - Stimulus: after 2 transfers, pulse rst, then send 3 nibbles from requester 2 (values 7, 8, 9).
   - Response: the partial word is never emitted. The next word is 12'h987, word_src=6'b101010, word_len=3.
